// File: rtl/mmu_tlb_lock_arb_pkg.sv
// Shared types and constants for the MMU TLB lock arbiter.
// The requester indices name the fixed rd/wr ports of the lookup mux.
package mmu_tlb_lock_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_DRAIN = 2'd2
   } tlb_arb_state_t;

   localparam int TLB_ARB_RD      = 0;
   localparam int TLB_ARB_WR      = 1;
   localparam int TLB_ARB_DRAIN_W = 4;

   function automatic int own_bits(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mmu_tlb_lock_arb_rr_pick.sv
// Combinational round-robin finder: first set bit of req starting at ptr, wrapping.
// ptr must be below N.
module mmu_tlb_lock_arb_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] idx,
   output logic         vld
);

   logic [N-1:0] rot_s;
   logic [W:0]   sum_s;

   assign rot_s = N'({req, req} >> ptr);

   // scan from the far end so the position closest to ptr is written last
   always_comb begin
      idx   = {W{1'b0}};
      vld   = 1'b0;
      sum_s = {(W+1){1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         sum_s = {1'b0, ptr} + (W+1)'(k);
         if (rot_s[k]) begin
            idx = (sum_s >= (W+1)'(N)) ? W'(sum_s - (W+1)'(N)) : W'(sum_s);
            vld = 1'b1;
         end else begin
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/mmu_tlb_lock_arb.sv
// Round-robin lock arbiter for the shared dTlb/sTlb lookup ports of one vFPGA MMU region.
// The mux select is held through a drain window so in-flight lookups reach their owner.
module mmu_tlb_lock_arb
   import mmu_tlb_lock_arb_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int TURN_CYCLES = 2,
   parameter int HOLD_MAX    = 1024,
   parameter int ID_REG      = 0
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [N_REQ-1:0]            lock_req,
   input  logic [N_REQ-1:0]            unlock,
   output logic [N_REQ-1:0]            lock_gnt,
   output logic [own_bits(N_REQ)-1:0]  owner_id,
   output logic                        owner_vld,
   output logic                        busy,
   output logic                        tmo_irq,
   output logic                        tmo_err,
   input  logic                        err_clr,
   output logic                        bad_unlock
);

   localparam int OWN_BITS = own_bits(N_REQ);
   localparam int HCW      = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam int DW       = TLB_ARB_DRAIN_W;

   localparam logic [HCW-1:0]   HOLD_LIM   = HCW'(HOLD_MAX);
   localparam logic [DW-1:0]    DRAIN_INIT = DW'(TURN_CYCLES - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
      $error("mmu_tlb_lock_arb: N_REQ must be 2..8");
   end
   if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
      $error("mmu_tlb_lock_arb: TURN_CYCLES must be 1..15");
   end
   if (HOLD_MAX < 0 || ID_REG < 0) begin : g_bad_misc
      $error("mmu_tlb_lock_arb: HOLD_MAX and ID_REG must be non-negative");
   end

   tlb_arb_state_t      state_r,      state_s;
   logic [N_REQ-1:0]    lock_gnt_r,   lock_gnt_s;
   logic [OWN_BITS-1:0] owner_id_r,   owner_id_s;
   logic                owner_vld_r,  owner_vld_s;
   logic                busy_r,       busy_s;
   logic                tmo_irq_r,    tmo_irq_s;
   logic                tmo_err_r,    tmo_err_s;
   logic                bad_unlock_r, bad_unlock_s;
   logic [OWN_BITS-1:0] rr_ptr_r,     rr_ptr_s;
   logic [HCW-1:0]      hold_cnt_r,   hold_cnt_s;
   logic [DW-1:0]       drain_cnt_r,  drain_cnt_s;

   logic [OWN_BITS-1:0] pick_idx_s;
   logic                pick_vld_s;
   logic [N_REQ-1:0]    owner_mask_s;
   logic [HCW-1:0]      hold_inc_s;
   logic                tmo_set_s;
   logic                bad_set_s;

   mmu_tlb_lock_arb_rr_pick #(
      .N (N_REQ),
      .W (OWN_BITS)
   ) u_rr_pick (
      .req (lock_req),
      .ptr (rr_ptr_r),
      .idx (pick_idx_s),
      .vld (pick_vld_s)
   );

   assign owner_mask_s = ONE_HOT0 << owner_id_r;
   assign hold_inc_s   = hold_cnt_r + HCW'(1);

   // next-state and next-output logic
   always_comb begin
      state_s     = state_r;
      lock_gnt_s  = lock_gnt_r;
      owner_id_s  = owner_id_r;
      owner_vld_s = owner_vld_r;
      rr_ptr_s    = rr_ptr_r;
      hold_cnt_s  = hold_cnt_r;
      drain_cnt_s = drain_cnt_r;
      tmo_irq_s   = 1'b0;
      tmo_set_s   = 1'b0;
      bad_set_s   = 1'b0;
      case (state_r)
         ARB_IDLE: begin
            bad_set_s = |unlock;
            if (pick_vld_s) begin
               state_s     = ARB_GRANT;
               lock_gnt_s  = ONE_HOT0 << pick_idx_s;
               owner_id_s  = pick_idx_s;
               owner_vld_s = 1'b1;
               rr_ptr_s    = (pick_idx_s == OWN_BITS'(N_REQ - 1)) ? OWN_BITS'(0)
                                                                   : pick_idx_s + OWN_BITS'(1);
               hold_cnt_s  = {HCW{1'b0}};
            end else begin
               state_s = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            bad_set_s = |(unlock & ~owner_mask_s);
            if (|(unlock & owner_mask_s)) begin
               state_s     = ARB_DRAIN;
               lock_gnt_s  = {N_REQ{1'b0}};
               owner_vld_s = 1'b0;
               drain_cnt_s = DRAIN_INIT;
            end else if (hold_cnt_r != HOLD_LIM) begin
               // HOLD_MAX of zero leaves hold_cnt parked at its limit, so no timeout
               hold_cnt_s = hold_inc_s;
               tmo_irq_s  = (hold_inc_s == HOLD_LIM);
               tmo_set_s  = (hold_inc_s == HOLD_LIM);
            end else begin
               hold_cnt_s = hold_cnt_r;
            end
         end
         ARB_DRAIN: begin
            bad_set_s = |unlock;
            if (drain_cnt_r == {DW{1'b0}}) begin
               state_s = ARB_IDLE;
            end else begin
               drain_cnt_s = drain_cnt_r - DW'(1);
            end
         end
         default: begin
            state_s     = ARB_IDLE;
            lock_gnt_s  = {N_REQ{1'b0}};
            owner_vld_s = 1'b0;
         end
      endcase
      busy_s       = (state_s != ARB_IDLE);
      tmo_err_s    = tmo_set_s | (tmo_err_r & ~err_clr);
      bad_unlock_s = bad_set_s | (bad_unlock_r & ~err_clr);
   end

   // state and registered outputs, synchronous reset
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r      <= ARB_IDLE;
         lock_gnt_r   <= {N_REQ{1'b0}};
         owner_id_r   <= OWN_BITS'(TLB_ARB_RD);
         owner_vld_r  <= 1'b0;
         busy_r       <= 1'b0;
         tmo_irq_r    <= 1'b0;
         tmo_err_r    <= 1'b0;
         bad_unlock_r <= 1'b0;
         rr_ptr_r     <= {OWN_BITS{1'b0}};
         hold_cnt_r   <= {HCW{1'b0}};
         drain_cnt_r  <= {DW{1'b0}};
      end else begin
         state_r      <= state_s;
         lock_gnt_r   <= lock_gnt_s;
         owner_id_r   <= owner_id_s;
         owner_vld_r  <= owner_vld_s;
         busy_r       <= busy_s;
         tmo_irq_r    <= tmo_irq_s;
         tmo_err_r    <= tmo_err_s;
         bad_unlock_r <= bad_unlock_s;
         rr_ptr_r     <= rr_ptr_s;
         hold_cnt_r   <= hold_cnt_s;
         drain_cnt_r  <= drain_cnt_s;
      end
   end

   assign lock_gnt   = lock_gnt_r;
   assign owner_id   = owner_id_r;
   assign owner_vld  = owner_vld_r;
   assign busy       = busy_r;
   assign tmo_irq    = tmo_irq_r;
   assign tmo_err    = tmo_err_r;
   assign bad_unlock = bad_unlock_r;

endmodule
